ifu_lsu_mem_arbiter: RTL and testbench

- Shares the single instruction/data memory port between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Accepts one request at a time, latches it, drives it downstream with a valid/ready handshake, and routes the response back to the owning requester.
- Round-robin on simultaneous requests.
- Response watchdog turns a hung memory into an error response.

---
 rtl/ifu_lsu_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ifu_lsu_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_lsu_mem_arbiter.sv
// rtl/ifu_lsu_mem_arbiter.sv - IFU/LSU shared memory port arbiter with response watchdog
module ifu_lsu_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    input  logic                mem_resp_err,

    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             owner_q;
    logic             last_owner_q;
    logic [CNT_W-1:0] wd_cnt_q;

    logic             grant_ifu;
    logic             grant_lsu;
    logic             resp_hit;
    logic             timeout_hit;
    logic             resp_done;
    logic [DATA_W-1:0] resp_data;
    logic             resp_err;

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, round-robin grant and response routing
    always_comb begin
        state_d        = state_q;
        grant_ifu      = 1'b0;
        grant_lsu      = 1'b0;
        resp_hit       = 1'b0;
        timeout_hit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rst) begin
                    // IFU wins a tie unless it owned the previous transaction
                    grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_owner_q == OWN_LSU));
                    grant_lsu = lsu_req_valid && !grant_ifu;
                    if (grant_ifu || grant_lsu) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!rst) begin
                    // A real response in the expiry cycle takes priority over the timeout
                    resp_hit    = mem_resp_valid;
                    timeout_hit = (TIMEOUT != 0) && !mem_resp_valid && (wd_cnt_q == CNT_LAST);
                    if (resp_hit || timeout_hit) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        resp_done = resp_hit || timeout_hit;
        resp_data = resp_hit ? mem_resp_rdata : '0;
        resp_err  = resp_hit ? mem_resp_err : 1'b1;

        ifu_req_ready  = grant_ifu;
        lsu_req_ready  = grant_lsu;

        ifu_resp_valid = resp_done && (owner_q == OWN_IFU);
        ifu_resp_data  = ifu_resp_valid ? resp_data : '0;
        ifu_resp_err   = ifu_resp_valid && resp_err;

        lsu_resp_valid = resp_done && (owner_q == OWN_LSU);
        lsu_resp_rdata = lsu_resp_valid ? resp_data : '0;
        lsu_resp_err   = lsu_resp_valid && resp_err;
    end

    // Request latch, ownership tracking and response watchdog counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            owner_q       <= OWN_IFU;
            last_owner_q  <= OWN_LSU;
            wd_cnt_q      <= '0;
        end else begin
            if (grant_ifu) begin
                // Fetches are always reads, so the store fields are forced clear
                mem_req_addr  <= ifu_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= '0;
                mem_req_wmask <= {MASK_W{1'b0}};
                owner_q       <= OWN_IFU;
                last_owner_q  <= OWN_IFU;
            end else if (grant_lsu) begin
                mem_req_addr  <= lsu_req_addr;
                mem_req_wen   <= lsu_req_wen;
                mem_req_wdata <= lsu_req_wdata;
                mem_req_wmask <= lsu_req_wmask;
                owner_q       <= OWN_LSU;
                last_owner_q  <= OWN_LSU;
            end

            if ((state_q == S_REQ) && mem_req_ready) begin
                wd_cnt_q <= '0;
            end else if ((state_q == S_RESP) && !resp_done) begin
                wd_cnt_q <= wd_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifu_lsu_mem_arbiter.sv
// tb/tb_ifu_lsu_mem_arbiter.sv - directed vector bench for ifu_lsu_mem_arbiter
module tb_ifu_lsu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        busy;

    ifu_lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        lw;
        logic [31:0] ld;
        logic [3:0]  lm;
        logic        mrdy;
        logic        mrv;
        logic [31:0] mrd;
        logic        mre;
    } in_t;

    typedef struct packed {
        logic        ird;
        logic        lrd;
        logic        mv;
        logic [31:0] ma;
        logic        mw;
        logic [31:0] md;
        logic [3:0]  mm;
        logic        irv;
        logic [31:0] idat;
        logic        ire;
        logic        lrv;
        logic [31:0] ldat;
        logic        lre;
        logic        busy;
    } out_t;

    typedef struct {
        string name;
        in_t   inp;
        out_t  exp;
    } vec_t;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] A = 32'h8000_0000;
    localparam logic [31:0] B = 32'h8000_1000;
    localparam logic [31:0] C = 32'h8000_0004;
    localparam logic [31:0] D = 32'hDEAD_BEEF;
    localparam logic [31:0] Z = 32'h0;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    function automatic in_t mk_in(logic r, logic iv, logic [31:0] ia, logic lv, logic [31:0] la,
                                  logic lw, logic [31:0] ld, logic [3:0] lm, logic mrdy,
                                  logic mrv, logic [31:0] mrd, logic mre);
        in_t v;
        v = '{r, iv, ia, lv, la, lw, ld, lm, mrdy, mrv, mrd, mre};
        return v;
    endfunction

    function automatic out_t mk_out(logic ird, logic lrd, logic mv, logic [31:0] ma, logic mw,
                                    logic [31:0] md, logic [3:0] mm, logic irv, logic [31:0] idat,
                                    logic ire, logic lrv, logic [31:0] ldat, logic lre, logic bz);
        out_t v;
        v = '{ird, lrd, mv, ma, mw, md, mm, irv, idat, ire, lrv, ldat, lre, bz};
        return v;
    endfunction

    function automatic out_t observe();
        out_t o;
        o = '{ifu_req_ready, lsu_req_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
              mem_req_wmask, ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid,
              lsu_resp_rdata, lsu_resp_err, busy};
        return o;
    endfunction

    task automatic add(input string n, input in_t i, input out_t o);
        vec_t v;
        v.name = n;
        v.inp  = i;
        v.exp  = o;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t v);
        rst            = v.rst;
        ifu_req_valid  = v.iv;
        ifu_req_addr   = v.ia;
        lsu_req_valid  = v.lv;
        lsu_req_addr   = v.la;
        lsu_req_wen    = v.lw;
        lsu_req_wdata  = v.ld;
        lsu_req_wmask  = v.lm;
        mem_req_ready  = v.mrdy;
        mem_resp_valid = v.mrv;
        mem_resp_rdata = v.mrd;
        mem_resp_err   = v.mre;
    endtask

    task automatic chk_out(input string name, input out_t act, input out_t exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        out_t   e;
        logic [31:0] exp_ma;
        logic [3:0]  gbits;
        int     grants[$];

        drive(mk_in(H, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L));
        repeat (2) @(posedge clk);

        // single fetch, store with backpressure, error passthrough, stale responses
        add("reset_idle",  mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L), mk_out(L, L, L, Z, L, Z, 4'h0, L, Z, L, L, Z, L, L));
        add("ifu_grant",   mk_in(L, H, A, L, Z, L, Z, 4'h0, L, L, Z, L), mk_out(H, L, L, Z, L, Z, 4'h0, L, Z, L, L, Z, L, L));
        add("ifu_req",     mk_in(L, L, Z, L, Z, L, Z, 4'h0, H, L, Z, L), mk_out(L, L, H, A, L, Z, 4'h0, L, Z, L, L, Z, L, H));
        add("ifu_resp",    mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, H, 32'h0000_0413, L), mk_out(L, L, L, A, L, Z, 4'h0, H, 32'h0000_0413, L, L, Z, L, H));
        add("ifu_done",    mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L), mk_out(L, L, L, A, L, Z, 4'h0, L, Z, L, L, Z, L, L));
        add("lsu_grant",   mk_in(L, L, Z, H, B, H, D, 4'hF, L, L, Z, L), mk_out(L, H, L, A, L, Z, 4'h0, L, Z, L, L, Z, L, L));
        for (int i = 0; i < 3; i++)
            add($sformatf("st_hold%0d", i), mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L), mk_out(L, L, H, B, H, D, 4'hF, L, Z, L, L, Z, L, H));
        add("st_accept",   mk_in(L, L, Z, L, Z, L, Z, 4'h0, H, L, Z, L), mk_out(L, L, H, B, H, D, 4'hF, L, Z, L, L, Z, L, H));
        add("st_ack",      mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, H, 32'h0000_00AC, L), mk_out(L, L, L, B, H, D, 4'hF, L, Z, L, H, 32'h0000_00AC, L, H));
        add("err_grant",   mk_in(L, H, C, L, Z, L, Z, 4'h0, L, L, Z, L), mk_out(H, L, L, B, H, D, 4'hF, L, Z, L, L, Z, L, L));
        add("early_resp",  mk_in(L, L, Z, L, Z, L, Z, 4'h0, H, H, 32'hFFFF_FFFF, H), mk_out(L, L, H, C, L, Z, 4'h0, L, Z, L, L, Z, L, H));
        add("err_resp",    mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, H, 32'h1234_5678, H), mk_out(L, L, L, C, L, Z, 4'h0, H, 32'h1234_5678, H, L, Z, L, H));
        add("idle_stale",  mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, H, 32'h5555_5555, L), mk_out(L, L, L, C, L, Z, 4'h0, L, Z, L, L, Z, L, L));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].inp);
            #1;
            chk_out(tbl[i].name, observe(), tbl[i].exp);
        end

        // watchdog: LSU load with a silent memory, TIMEOUT = 4
        @(negedge clk);
        drive(mk_in(L, L, Z, H, 32'h8000_2000, L, Z, 4'h0, L, L, Z, L));
        #1;
        chk32("to_lsu_ready", 32'(lsu_req_ready), 32'd1);
        @(negedge clk);
        drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, H, L, Z, L));
        #1;
        chk32("to_req_addr", mem_req_addr, 32'h8000_2000);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, L, 32'hAAAA_5555, L));
            #1;
            e = mk_out(L, L, L, 32'h8000_2000, L, Z, 4'h0, L, Z, L, (i == 4), Z, (i == 4), H);
            chk_out($sformatf("to_resp_cycle%0d", i), observe(), e);
        end
        @(negedge clk);
        drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L));
        #1;
        e = mk_out(L, L, L, 32'h8000_2000, L, Z, 4'h0, L, Z, L, L, Z, L, L);
        chk_out("to_idle", observe(), e);
        @(negedge clk);
        drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, H, 32'h7777_7777, L));
        #1;
        chk_out("to_late_resp", observe(), e);

        // reset while waiting in RESP
        @(negedge clk);
        drive(mk_in(L, H, 32'h8000_0100, L, Z, L, Z, 4'h0, L, L, Z, L));
        #1;
        chk32("rr_ifu_ready", 32'(ifu_req_ready), 32'd1);
        @(negedge clk);
        drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, H, L, Z, L));
        #1;
        chk32("rr_req_valid", 32'(mem_req_valid), 32'd1);
        @(negedge clk);
        drive(mk_in(H, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L));
        @(negedge clk);
        drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L));
        #1;
        chk_out("rr_after_reset", observe(), '0);
        @(negedge clk);
        drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, H, 32'h9999_9999, H));
        #1;
        chk_out("rr_stale_resp", observe(), '0);

        // both requesters valid for four transactions; responder accepts and answers at once
        exp_ma = 32'h0;
        for (int k = 0; k < 12; k++) begin
            int   ph;
            logic own_lsu;
            ph      = k % 3;
            own_lsu = ((k / 3) % 2) == 1;
            @(negedge clk);
            drive(mk_in(L, H, 32'h100, H, 32'h200, L, Z, 4'h0, H, H, 32'hC0DE_0000 | 32'(k), L));
            #1;
            e = '0;
            if (ph == 0) begin
                e.ird = !own_lsu;
                e.lrd = own_lsu;
                e.ma  = exp_ma;
            end else begin
                exp_ma = own_lsu ? 32'h200 : 32'h100;
                e.ma   = exp_ma;
                e.busy = 1'b1;
                if (ph == 1) begin
                    e.mv = 1'b1;
                end else if (own_lsu) begin
                    e.lrv  = 1'b1;
                    e.ldat = 32'hC0DE_0000 | 32'(k);
                end else begin
                    e.irv  = 1'b1;
                    e.idat = 32'hC0DE_0000 | 32'(k);
                end
            end
            chk_out($sformatf("arb_cycle%0d", k), observe(), e);
            if (ifu_req_ready) grants.push_back(0);
            if (lsu_req_ready) grants.push_back(1);
        end
        chk32("arb_grant_count", 32'(grants.size()), 32'd4);
        gbits = 4'h0;
        for (int i = 0; i < 4 && i < grants.size(); i++) gbits[i] = (grants[i] == 1);
        chk32("arb_grant_order", 32'(gbits), 32'h0000_000A);

        @(negedge clk);
        drive(mk_in(L, L, Z, L, Z, L, Z, 4'h0, L, L, Z, L));
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
